uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver. It captures each byte on the rising edge of the receiver's done strobe and stores it in a circular FIFO. It presents the oldest byte to the host in first-word-fall-through form and flags overrun when bytes arrive with the FIFO full. Decouples serial byte arrival from host read timing.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_edge_detect.sv | 29 ++
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and their buffers.
//   UART_DATA_W        : width of one serial byte
//   UART_RX_FIFO_DEPTH : default number of entries in the receive FIFO
//   uart_byte_t        : one received or transmitted byte
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH = 16;

    typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_edge_detect.sv
// Rising-edge detector with a configurable reset value for its history flop.
// With RESET_VAL = 1, a level that is already high when reset releases does
// not produce a strobe.
//   clk_i   : system clock
//   reset_i : synchronous, active-high reset
//   level_i : level input to watch
//   rise_o  : one-cycle strobe, high while level_i is high and was low last cycle
module uart_edge_detect #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic level_i,
    output logic rise_o
);

    logic hist_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hist_q <= RESET_VAL;
        end else begin
            hist_q <= level_i;
        end
    end

    assign rise_o = level_i & ~hist_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO placed directly after the UART receiver. One byte is
// captured per rising edge of rx_done_i and stored in a circular buffer. The
// oldest byte is presented first-word-fall-through. A byte arriving while the
// FIFO is full and no pop is happening is dropped and flags a sticky overrun.
//   clk_i         : system clock
//   reset_i       : synchronous, active-high reset
//   rx_data_i     : byte from the receiver, valid while rx_done_i is high
//   rx_done_i     : receiver done level (may stay high for several cycles)
//   rd_en_i       : pop one entry this cycle (ignored while empty)
//   clr_overrun_i : clear the sticky overrun flag
//   rd_data_o     : oldest stored byte, valid while empty_o is low
//   empty_o       : no entries stored
//   full_o        : DEPTH entries stored
//   count_o       : number of stored entries, 0..DEPTH
//   overrun_o     : sticky, a byte was dropped because the FIFO was full
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_W = UART_DATA_W,
    parameter  int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_done_i,
    input  logic              rd_en_i,
    input  logic              clr_overrun_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AW:0]       count_o,
    output logic              overrun_o
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overrun_q, overrun_d;

    logic wr_stb;
    logic wr_en;
    logic pop;
    logic overrun_set;

    uart_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_done_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .level_i (rx_done_i),
        .rise_o  (wr_stb)
    );

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCount);

    // When full, a concurrent pop frees the slot the write lands in.
    assign pop         = rd_en_i & ~empty_o;
    assign wr_en       = wr_stb & (~full_o | rd_en_i);
    assign overrun_set = wr_stb & full_o & ~rd_en_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Set has priority over clear.
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once the pointers reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk;
    logic       reset;
    uart_byte_t rx_data;
    logic       rx_done;
    logic       rd_en;
    logic       clr_overrun;
    uart_byte_t rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;

    int vectors;
    int miscompares;

    uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rx_data_i     (rx_data),
        .rx_done_i     (rx_done),
        .rd_en_i       (rd_en),
        .clr_overrun_i (clr_overrun),
        .rd_data_o     (rd_data),
        .empty_o       (empty),
        .full_o        (full),
        .count_o       (count),
        .overrun_o     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle rx_done pulse followed by a low cycle so the next pulse is an edge.
    task automatic push_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop_byte();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h99;
        tick();
        tick();
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b overrun=%b, need 0 1 0 0",
                     count, empty, full, overrun);
        end
        // rx_done stays high across release: no write expected.
        reset = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_done_high: count=%0d empty=%b, need 0 1", count, empty);
        end
        rx_done = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        rx_data = 8'hA5;
        rx_done = 1'b1;
        tick();
        vectors++;
        if (empty !== 1'b0 || count !== 5'd1 || rd_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_write: empty=%b count=%0d rd_data=%h, need 0 1 a5",
                     empty, count, rd_data);
        end
        rx_done = 1'b0;
        tick();
        pop_byte();
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL single_pop: empty=%b count=%0d, need 1 0", empty, count);
        end
        // Pop while empty must change nothing.
        pop_byte();
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL pop_when_empty: empty=%b count=%0d, need 1 0", empty, count);
        end
    endtask

    task automatic test_long_done();
        rx_data = 8'h3C;
        rx_done = 1'b1;
        repeat (20) tick();
        vectors++;
        if (count !== 5'd1 || rd_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL long_done: count=%0d rd_data=%h, need 1 3c", count, rd_data);
        end
        rx_done = 1'b0;
        tick();
        pop_byte();
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL long_done_drain: empty=%b, need 1", empty);
        end
    endtask

    task automatic test_fill_order();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                push_byte(8'((r * 16) + i));
            end
            vectors++;
            if (full !== 1'b1 || count !== 5'd16 || empty !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_full r%0d: full=%b count=%0d empty=%b, need 1 16 0",
                         r, full, count, empty);
            end
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (rd_data !== 8'((r * 16) + i)) begin
                    miscompares++;
                    $display("FAIL fill_order r%0d i%0d: rd_data=%h, need %h",
                             r, i, rd_data, 8'((r * 16) + i));
                end
                pop_byte();
            end
            vectors++;
            if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_drain r%0d: empty=%b count=%0d full=%b, need 1 0 0",
                         r, empty, count, full);
            end
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(8'h40 + i));
        end
        push_byte(8'hFF);
        vectors++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL overrun_set: overrun=%b count=%0d, need 1 16", overrun, count);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: overrun=%b, need 0", overrun);
        end
        // Clear and a fresh overrun in the same cycle: set wins.
        rx_data     = 8'hEE;
        rx_done     = 1'b1;
        clr_overrun = 1'b1;
        tick();
        rx_done     = 1'b0;
        clr_overrun = 1'b0;
        vectors++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL overrun_set_wins: overrun=%b count=%0d, need 1 16", overrun, count);
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (rd_data !== 8'(8'h40 + i)) begin
                miscompares++;
                $display("FAIL overrun_readback i%0d: rd_data=%h, need %h",
                         i, rd_data, 8'(8'h40 + i));
            end
            pop_byte();
        end
        vectors++;
        if (empty !== 1'b1 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_drain: empty=%b overrun=%b, need 1 1", empty, overrun);
        end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(8'h50 + i));
        end
        rx_data = 8'h77;
        rx_done = 1'b1;
        rd_en   = 1'b1;
        tick();
        rx_done = 1'b0;
        rd_en   = 1'b0;
        vectors++;
        if (count !== 5'd16 || full !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_full: count=%0d full=%b overrun=%b, need 16 1 0",
                     count, full, overrun);
        end
        tick();
        for (int i = 1; i < 17; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 16) ? 8'h77 : 8'(8'h50 + i);
            vectors++;
            if (rd_data !== exp_b) begin
                miscompares++;
                $display("FAIL simul_full_order i%0d: rd_data=%h, need %h", i, rd_data, exp_b);
            end
            pop_byte();
        end
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_full_drain: empty=%b, need 1", empty);
        end
        // Write and pop on an empty FIFO: only the write takes effect.
        rx_data = 8'h88;
        rx_done = 1'b1;
        rd_en   = 1'b1;
        tick();
        rx_done = 1'b0;
        rd_en   = 1'b0;
        vectors++;
        if (count !== 5'd1 || empty !== 1'b0 || rd_data !== 8'h88) begin
            miscompares++;
            $display("FAIL simul_empty: count=%0d empty=%b rd_data=%h, need 1 0 88",
                     count, empty, rd_data);
        end
        tick();
        pop_byte();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(8'hC0 + i));
        end
        push_byte(8'hFE);
        for (int i = 0; i < 11; i++) begin
            pop_byte();
        end
        vectors++;
        if (count !== 5'd5 || overrun !== 1'b1 || rd_data !== 8'hCB) begin
            miscompares++;
            $display("FAIL pre_reset: count=%0d overrun=%b rd_data=%h, need 5 1 cb",
                     count, overrun, rd_data);
        end
        reset = 1'b1;
        rd_en = 1'b1;
        tick();
        reset = 1'b0;
        rd_en = 1'b0;
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0 || overrun !== 1'b0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: empty=%b count=%0d overrun=%b full=%b, need 1 0 0 0",
                     empty, count, overrun, full);
        end
        tick();
        push_byte(8'h5A);
        vectors++;
        if (count !== 5'd1 || rd_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL post_reset_write: count=%0d rd_data=%h, need 1 5a", count, rd_data);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        rx_data     = 8'h00;
        rx_done     = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;

        test_reset();
        test_single_byte();
        test_long_done();
        test_fill_order();
        test_overrun();
        test_simultaneous();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
